// File: rtl/nvio3_shift_pipe.sv
// nvio3_shift_pipe: pipelined shift/rotate unit for the nvio3 integer ALU path.
// The shift amount is split into STAGES bit groups; each stage applies its own
// group to the partial result and registers it together with the op, original
// sign, running overflow and tag. An elastic valid/ready chain lets downstream
// back-pressure stall the pipe without dropping or duplicating operations.
module nvio3_shift_pipe #(
    parameter int WID         = 64,
    parameter int STAGES      = 2,
    parameter int TAGW        = 6,
    parameter int ROTATE_INSN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [WID-1:0]        a_i,
    input  logic [$clog2(WID):0]  b_i,
    input  logic [TAGW-1:0]       tag_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WID-1:0]        res_o,
    output logic                  ov_o,
    output logic [TAGW-1:0]       tag_o
);

    localparam int SW = $clog2(WID);

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_ASL = 3'd1;
    localparam logic [2:0] OP_SHR = 3'd2;
    localparam logic [2:0] OP_ASR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;

    localparam logic [WID-1:0] ROT_OFF  = {(WID/16){16'hDEAD}};
    localparam logic [WID-1:0] MSB_MASK = {1'b1, {(WID-1){1'b0}}};

    // Amount bits handled by stage k: [k*SW/STAGES, (k+1)*SW/STAGES).
    function automatic logic [SW-1:0] grp_mask(input int k);
        int lo;
        int hi;
        lo = (k * SW) / STAGES;
        hi = ((k + 1) * SW) / STAGES;
        return SW'((32'd1 << hi) - (32'd1 << lo));
    endfunction

    // One partial shift by g. For left shifts, the top g+1 bits of the partial
    // value must all match the original sign, otherwise significant bits are
    // lost; accumulated across stages this covers a[WID-1 -: s+1].
    function automatic logic [WID:0] shift_step(
        input logic [2:0]     op,
        input logic [WID-1:0] x,
        input logic [SW-1:0]  g,
        input logic           sign,
        input logic           ov_in
    );
        logic [2*WID-1:0] dbl;
        logic [WID-1:0]   r;
        logic [WID-1:0]   m;
        logic             o;
        dbl = '0;
        r   = '0;
        o   = 1'b0;
        m   = ~({WID{1'b1}} >> g);
        m   = m | (m >> 1) | MSB_MASK;
        case (op)
            OP_SHL, OP_ASL: begin
                r = x << g;
                o = ov_in | (|((x ^ {WID{sign}}) & m));
            end
            OP_SHR: r = x >> g;
            OP_ASR: begin
                dbl = {{WID{sign}}, x} >> g;
                r   = dbl[WID-1:0];
            end
            OP_ROL: begin
                if (ROTATE_INSN != 0) begin
                    dbl = {x, x} << g;
                    r   = dbl[2*WID-1:WID];
                end else begin
                    r = ROT_OFF;
                end
            end
            OP_ROR: begin
                if (ROTATE_INSN != 0) begin
                    dbl = {x, x} >> g;
                    r   = dbl[WID-1:0];
                end else begin
                    r = ROT_OFF;
                end
            end
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    // Stage registers.
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] sign_r;
    logic [STAGES-1:0] ov_r;
    logic [WID-1:0]    res_r [STAGES];
    logic [2:0]        op_r  [STAGES];
    logic [SW-1:0]     amt_r [STAGES];
    logic [TAGW-1:0]   tag_r [STAGES];

    // Stage inputs and per-stage load enables.
    logic [STAGES-1:0] src_v_s;
    logic [STAGES-1:0] src_sign_s;
    logic [STAGES-1:0] src_ov_s;
    logic [WID-1:0]    src_x_s   [STAGES];
    logic [2:0]        src_op_s  [STAGES];
    logic [SW-1:0]     src_amt_s [STAGES];
    logic [TAGW-1:0]   src_tag_s [STAGES];
    logic [WID:0]      step_s    [STAGES];
    logic [STAGES-1:0] en_s;
    logic              unused_s;

    // Select what each stage loads: the issue port for stage 0, the previous stage otherwise.
    always_comb begin
        src_v_s      = '0;
        src_sign_s   = '0;
        src_ov_s     = '0;
        src_v_s[0]   = valid_i;
        src_sign_s[0] = a_i[WID-1];
        src_ov_s[0]  = 1'b0;
        src_x_s[0]   = a_i;
        src_op_s[0]  = op_i;
        src_amt_s[0] = b_i[SW-1:0];
        src_tag_s[0] = tag_i;
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k]    = v_r[k-1];
            src_sign_s[k] = sign_r[k-1];
            src_ov_s[k]   = ov_r[k-1];
            src_x_s[k]    = res_r[k-1];
            src_op_s[k]   = op_r[k-1];
            src_amt_s[k]  = amt_r[k-1];
            src_tag_s[k]  = tag_r[k-1];
        end
    end

    // Apply each stage's group of amount bits to its incoming partial result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            step_s[k] = shift_step(src_op_s[k], src_x_s[k],
                                   src_amt_s[k] & grp_mask(k),
                                   src_sign_s[k], src_ov_s[k]);
        end
    end

    // Stage k may load when it is empty or when everything after it can move.
    always_comb begin : p_enable
        logic d;
        d    = ready_i;
        en_s = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            d       = ~v_r[k] | d;
            en_s[k] = d;
        end
    end

    // Pipeline registers; payload only loads for a valid slot so bubbles leave it untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_r    <= '0;
            sign_r <= '0;
            ov_r   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_r[k] <= '0;
                op_r[k]  <= '0;
                amt_r[k] <= '0;
                tag_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en_s[k]) begin
                    v_r[k] <= src_v_s[k];
                    if (src_v_s[k]) begin
                        res_r[k]  <= step_s[k][WID-1:0];
                        ov_r[k]   <= step_s[k][WID];
                        sign_r[k] <= src_sign_s[k];
                        op_r[k]   <= src_op_s[k];
                        amt_r[k]  <= src_amt_s[k];
                        tag_r[k]  <= src_tag_s[k];
                    end
                end
            end
        end
    end

    assign ready_o  = en_s[0];
    assign valid_o  = v_r[STAGES-1];
    assign res_o    = res_r[STAGES-1];
    assign ov_o     = ov_r[STAGES-1];
    assign tag_o    = tag_r[STAGES-1];

    // The amount MSB is ignored (shift is modulo WID); last-stage side fields have no consumer.
    assign unused_s = ^{b_i[SW], sign_r[STAGES-1], op_r[STAGES-1], amt_r[STAGES-1]};

endmodule

// File: tb/tb_nvio3_shift_pipe.sv
// Directed bench for nvio3_shift_pipe at WID=32, STAGES=2, with a second
// instance built without rotate support.
module tb_nvio3_shift_pipe;

    localparam int WID    = 32;
    localparam int STAGES = 2;
    localparam int TAGW   = 6;
    localparam int BW     = 6;

    logic            clk;
    logic            rst_n;
    logic            valid_in;
    logic            ready_out;
    logic [2:0]      op;
    logic [WID-1:0]  a;
    logic [BW-1:0]   b;
    logic [TAGW-1:0] tag;
    logic            valid_out;
    logic            ready_in;
    logic [WID-1:0]  res;
    logic            ov;
    logic [TAGW-1:0] tag_out;

    logic            rd_ready;
    logic            rd_valid;
    logic [WID-1:0]  rd_res;
    logic            rd_ov;
    logic [TAGW-1:0] rd_tag;

    int checks = 0;
    int errors = 0;

    nvio3_shift_pipe #(.WID(WID), .STAGES(STAGES), .TAGW(TAGW), .ROTATE_INSN(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ready_out),
        .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .valid_o(valid_out),
        .ready_i(ready_in), .res_o(res), .ov_o(ov), .tag_o(tag_out)
    );

    nvio3_shift_pipe #(.WID(WID), .STAGES(STAGES), .TAGW(TAGW), .ROTATE_INSN(0)) dut_norot (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(rd_ready),
        .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .valid_o(rd_valid),
        .ready_i(ready_in), .res_o(rd_res), .ov_o(rd_ov), .tag_o(rd_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Issue one op into an empty pipe with ready_in high and check it two cycles later.
    task automatic run_one(input logic [2:0] o, input logic [31:0] av, input logic [5:0] bv,
                           input logic [5:0] tg, input logic [31:0] er, input logic eo,
                           input logic [31:0] erd, input string nm);
        op = o; a = av; b = bv; tag = tg; valid_in = 1'b1; ready_in = 1'b1;
        #1;
        chk({nm, "_ready"}, 64'(ready_out), 64'd1);
        tick();
        valid_in = 1'b0;
        chk({nm, "_lat1"}, 64'(valid_out), 64'd0);
        tick();
        chk({nm, "_valid"}, 64'(valid_out), 64'd1);
        chk({nm, "_res"}, 64'(res), 64'(er));
        chk({nm, "_ov"}, 64'(ov), 64'(eo));
        chk({nm, "_tag"}, 64'(tag_out), 64'(tg));
        chk({nm, "_norot_res"}, 64'(rd_res), 64'(erd));
        tick();
    endtask

    initial begin
        logic [31:0] av;
        logic [31:0] ev;

        clk = 1'b0; rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        op = 3'd0; a = 32'd0; b = 6'd0; tag = 6'd0;

        // Reset state
        #12;
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_ov", 64'(ov), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(ready_out), 64'd1);

        // Directed single operations
        run_one(3'd0, 32'h0000_0001, 6'd31, 6'd5,  32'h8000_0000, 1'b1, 32'h8000_0000, "shl_31");
        run_one(3'd3, 32'h8000_0000, 6'd4,  6'd6,  32'hF800_0000, 1'b0, 32'hF800_0000, "asr_4");
        run_one(3'd2, 32'h8000_0000, 6'd4,  6'd7,  32'h0800_0000, 1'b0, 32'h0800_0000, "shr_4");
        run_one(3'd1, 32'hFFFF_FFFF, 6'd8,  6'd8,  32'hFFFF_FF00, 1'b0, 32'hFFFF_FF00, "asl_neg");
        run_one(3'd4, 32'h1234_5678, 6'd8,  6'd9,  32'h3456_7812, 1'b0, 32'hDEAD_DEAD, "rol_8");
        run_one(3'd5, 32'h1234_5678, 6'd8,  6'd10, 32'h7812_3456, 1'b0, 32'hDEAD_DEAD, "ror_8");
        run_one(3'd0, 32'h0000_0003, 6'd33, 6'd11, 32'h0000_0006, 1'b0, 32'h0000_0006, "amt_wrap");
        run_one(3'd1, 32'h0040_0000, 6'd9,  6'd12, 32'h8000_0000, 1'b1, 32'h8000_0000, "asl_ov_mid");
        run_one(3'd1, 32'h0020_0000, 6'd9,  6'd13, 32'h4000_0000, 1'b0, 32'h4000_0000, "asl_edge");
        run_one(3'd3, 32'h8000_0000, 6'd31, 6'd14, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, "asr_31");
        run_one(3'd2, 32'h8000_0000, 6'd31, 6'd15, 32'h0000_0001, 1'b0, 32'h0000_0001, "shr_31");
        run_one(3'd5, 32'h0000_0001, 6'd1,  6'd16, 32'h8000_0000, 1'b0, 32'hDEAD_DEAD, "ror_1");
        run_one(3'd6, 32'h0000_FFFF, 6'd3,  6'd17, 32'h0000_0000, 1'b0, 32'h0000_0000, "op6");
        run_one(3'd7, 32'hFFFF_FFFF, 6'd0,  6'd18, 32'h0000_0000, 1'b0, 32'h0000_0000, "op7");
        run_one(3'd0, 32'h8765_4321, 6'd0,  6'd19, 32'h8765_4321, 1'b0, 32'h8765_4321, "s0_shl");
        run_one(3'd1, 32'h8765_4321, 6'd0,  6'd20, 32'h8765_4321, 1'b0, 32'h8765_4321, "s0_asl");
        run_one(3'd2, 32'h8765_4321, 6'd32, 6'd21, 32'h8765_4321, 1'b0, 32'h8765_4321, "s0_shr");
        run_one(3'd3, 32'h8765_4321, 6'd0,  6'd22, 32'h8765_4321, 1'b0, 32'h8765_4321, "s0_asr");
        run_one(3'd4, 32'h8765_4321, 6'd0,  6'd23, 32'h8765_4321, 1'b0, 32'hDEAD_DEAD, "s0_rol");
        run_one(3'd5, 32'h8765_4321, 6'd0,  6'd24, 32'h8765_4321, 1'b0, 32'hDEAD_DEAD, "s0_ror");

        // Ten back-to-back ops; results must come out on consecutive cycles in order
        ready_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                av = 32'((i - 2) * 3 + 1);
                ev = av << (i - 2);
                chk("stream_valid", 64'(valid_out), 64'd1);
                chk("stream_tag", 64'(tag_out), 64'(i - 2 + 40));
                chk("stream_res", 64'(res), 64'(ev));
            end else begin
                chk("stream_empty", 64'(valid_out), 64'd0);
            end
            if (i < 10) begin
                valid_in = 1'b1; op = 3'd0; a = 32'(i * 3 + 1); b = 6'(i); tag = 6'(i + 40);
                #1;
                chk("stream_ready", 64'(ready_out), 64'd1);
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
        chk("stream_done", 64'(valid_out), 64'd0);

        // Stall: two ops fill the pipe, third waits, outputs hold, then drain in order
        ready_in = 1'b0;
        valid_in = 1'b1; op = 3'd2; a = 32'h0000_00F0; b = 6'd4; tag = 6'd20;
        #1;
        chk("stall_rdy0", 64'(ready_out), 64'd1);
        tick();
        op = 3'd5; a = 32'h0000_0001; b = 6'd1; tag = 6'd21;
        chk("stall_rdy1", 64'(ready_out), 64'd1);
        tick();
        op = 3'd3; a = 32'h8000_0000; b = 6'd1; tag = 6'd22;
        #1;
        chk("stall_full", 64'(ready_out), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold_valid", 64'(valid_out), 64'd1);
            chk("stall_hold_tag", 64'(tag_out), 64'd20);
            chk("stall_hold_res", 64'(res), 64'h0000_000F);
            tick();
            chk("stall_hold_rdy", 64'(ready_out), 64'd0);
        end
        ready_in = 1'b1;
        #1;
        chk("stall_release_rdy", 64'(ready_out), 64'd1);
        tick();
        valid_in = 1'b0;
        chk("drain_b_valid", 64'(valid_out), 64'd1);
        chk("drain_b_tag", 64'(tag_out), 64'd21);
        chk("drain_b_res", 64'(res), 64'h8000_0000);
        tick();
        chk("drain_c_valid", 64'(valid_out), 64'd1);
        chk("drain_c_tag", 64'(tag_out), 64'd22);
        chk("drain_c_res", 64'(res), 64'hC000_0000);
        tick();
        chk("drain_empty", 64'(valid_out), 64'd0);

        // Asynchronous reset with two ops in flight
        valid_in = 1'b1; op = 3'd0; a = 32'h0000_0001; b = 6'd31; tag = 6'd30;
        tick();
        op = 3'd2; a = 32'h0000_0100; b = 6'd4; tag = 6'd31;
        tick();
        valid_in = 1'b0;
        chk("pre_rst_valid", 64'(valid_out), 64'd1);
        chk("pre_rst_ov", 64'(ov), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(valid_out), 64'd0);
        chk("async_rst_res", 64'(res), 64'd0);
        chk("async_rst_ov", 64'(ov), 64'd0);
        chk("async_rst_tag", 64'(tag_out), 64'd0);
        chk("async_rst_norot_valid", 64'(rd_valid), 64'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 64'(valid_out), 64'd0);
            chk("post_rst_ready", 64'(ready_out), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
